// File: rtl/mips_16_core_top.sv
// Five-stage 16-bit MIPS-style core (IF/ID/EX/MEM/WB) with interlocks on pending
// EX/MEM writes, jumps resolved in ID, branches resolved in EX, and a sticky HALT.

module instr_rom (
    input  logic [7:0]  addr,
    output logic [15:0] data
);
    // Contents are loaded from outside the core; asynchronous read.
    logic [15:0] rom [0:255];

    assign data = rom[addr];
endmodule

module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [7:0]  target,
    input  logic        hold,
    input  logic        flush,
    output logic [7:0]  pc,
    output logic [15:0] instr,
    output logic [7:0]  instr_pc
);
    logic [15:0] fetched;

    instr_rom imem (.addr(pc), .data(fetched));

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every stage samples the values from before this edge.
        if (rst) begin
            pc       <= 8'd0;
            instr    <= 16'h0000;
            instr_pc <= 8'd0;
        end else if (redirect) begin
            pc    <= target;
            instr <= 16'h0000;
        end else if (hold) begin
            if (flush) instr <= 16'h0000;
        end else begin
            pc       <= pc + 8'd1;
            instr    <= fetched;
            instr_pc <= pc;
        end
    end
endmodule

module regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ra,
    input  logic [2:0]  rb,
    output logic [15:0] da,
    output logic [15:0] db,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd
);
    logic [15:0] re_array [0:7];

    // Write-through: a read of the register being written returns the new value.
    assign da = (ra == 3'd0) ? 16'h0000 : (we && wa == ra) ? wd : re_array[ra];
    assign db = (rb == 3'd0) ? 16'h0000 : (we && wa == rb) ? wd : re_array[rb];

    always_ff @(posedge clk) begin
        // NOTE: the architectural registers are cleared on reset; ROM and DMEM never are.
        if (rst) begin
            for (int i = 0; i < 8; i++) re_array[i] <= 16'h0000;
        end else if (we && wa != 3'd0) begin
            re_array[wa] <= wd;
        end
    end
endmodule

module mips_16_core_top (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] pc
);
    typedef enum logic [3:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL,
        OP_ADDI, OP_LW, OP_SW, OP_LI, OP_BZ, OP_BNZ, OP_JMP, OP_HALT
    } opcode_t;

    logic [15:0] id_instr;
    logic [7:0]  id_pc;
    opcode_t     id_op;
    logic [2:0]  id_rd, id_rs1, id_rb;
    logic        id_use_a, id_use_b, id_wr, id_stall;
    logic [15:0] rf_a, rf_b;
    logic        halted, redirect, hold, flush;
    logic [7:0]  target;

    opcode_t     ex_op;
    logic [2:0]  ex_rd;
    logic        ex_wr;
    logic [15:0] ex_a, ex_b, ex_res, imm6_x, imm9_x;
    logic [8:0]  ex_ir;
    logic [7:0]  ex_pc, ex_target;
    logic        ex_taken;

    opcode_t     mem_op;
    logic [2:0]  mem_rd, wb_rd;
    logic        mem_wr, wb_wr;
    logic [15:0] mem_res, mem_data, wb_val;
    logic [15:0] dmem [0:255];

    if_stage IF_stage_inst (
        .clk(clk), .rst(rst), .redirect(redirect), .target(target), .hold(hold),
        .flush(flush), .pc(pc), .instr(id_instr), .instr_pc(id_pc)
    );

    assign id_op    = opcode_t'(id_instr[15:12]);
    assign id_rd    = id_instr[11:9];
    assign id_rs1   = id_instr[8:6];
    assign id_rb    = (id_op inside {OP_SW, OP_BZ, OP_BNZ}) ? id_rd : id_instr[5:3];
    assign id_use_a = id_op inside {[OP_ADD:OP_SW]};
    assign id_use_b = id_op inside {[OP_ADD:OP_SRL], OP_SW, OP_BZ, OP_BNZ};
    assign id_wr    = (id_op inside {[OP_ADD:OP_LW], OP_LI}) && (id_rd != 3'd0);

    // Only EX and MEM can hold a pending write; WB is covered by write-through.
    assign id_stall = (id_use_a && ((ex_wr && ex_rd == id_rs1) || (mem_wr && mem_rd == id_rs1)))
                   || (id_use_b && ((ex_wr && ex_rd == id_rb) || (mem_wr && mem_rd == id_rb)));

    regfile check_inst (
        .clk(clk), .rst(rst), .ra(id_rs1), .rb(id_rb), .da(rf_a), .db(rf_b),
        .we(wb_wr), .wa(wb_rd), .wd(wb_val)
    );

    assign imm6_x    = {{10{ex_ir[5]}}, ex_ir[5:0]};
    assign imm9_x    = {{7{ex_ir[8]}}, ex_ir};
    assign ex_taken  = (ex_op == OP_BZ && ex_b == 16'h0000) || (ex_op == OP_BNZ && ex_b != 16'h0000);
    assign ex_target = ex_pc + 8'd1 + imm9_x[7:0];

    always_comb begin
        // NOTE: default first so every path assigns ex_res and no latch is inferred.
        ex_res = 16'h0000;
        case (ex_op)
            OP_ADD:               ex_res = ex_a + ex_b;
            OP_SUB:               ex_res = ex_a - ex_b;
            OP_AND:               ex_res = ex_a & ex_b;
            OP_OR:                ex_res = ex_a | ex_b;
            OP_XOR:               ex_res = ex_a ^ ex_b;
            OP_SLL:               ex_res = ex_a << ex_b[3:0];
            OP_SRL:               ex_res = ex_a >> ex_b[3:0];
            OP_ADDI, OP_LW, OP_SW: ex_res = ex_a + imm6_x;
            OP_LI:                ex_res = imm9_x;
            default:              ex_res = 16'h0000;
        endcase
    end

    // A taken branch is older than whatever sits in ID, so it overrides stall, JMP and HALT.
    assign redirect = ex_taken || id_op == OP_JMP;
    assign target   = ex_taken ? ex_target : id_instr[7:0];
    assign hold     = halted || id_op == OP_HALT || id_stall;
    assign flush    = halted || id_op == OP_HALT;

    always_ff @(posedge clk) begin
        if (rst) halted <= 1'b0;
        else if (id_op == OP_HALT && !ex_taken) halted <= 1'b1;
    end

    always_ff @(posedge clk) begin
        ex_a  <= rf_a;
        ex_b  <= rf_b;
        ex_ir <= id_instr[8:0];
        ex_pc <= id_pc;
        ex_rd <= id_rd;
        if (rst || ex_taken || id_stall) begin
            ex_op <= OP_NOP;
            ex_wr <= 1'b0;
        end else begin
            ex_op <= id_op;
            ex_wr <= id_wr;
        end
    end

    always_ff @(posedge clk) begin
        mem_rd   <= ex_rd;
        mem_res  <= ex_res;
        mem_data <= ex_b;
        if (rst) begin
            mem_op <= OP_NOP;
            mem_wr <= 1'b0;
        end else begin
            mem_op <= ex_op;
            mem_wr <= ex_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_op == OP_SW) dmem[mem_res[7:0]] <= mem_data;
    end

    always_ff @(posedge clk) begin
        wb_rd  <= mem_rd;
        wb_val <= (mem_op == OP_LW) ? dmem[mem_res[7:0]] : mem_res;
        if (rst) wb_wr <= 1'b0;
        else     wb_wr <= mem_wr;
    end
endmodule

// File: tb/tb_mips_16_core_top.sv
// Bench for mips_16_core_top: directed programs, an opcode vector table, and random
// programs checked against an instruction-level interpreter of the ISA.

module tb_mips_16_core_top;
    localparam logic [3:0] OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3, OP_OR = 4'd4,
                           OP_XOR = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7, OP_ADDI = 4'd8,
                           OP_LW = 4'd9, OP_SW = 4'd10, OP_LI = 4'd11, OP_BZ = 4'd12,
                           OP_BNZ = 4'd13;
    localparam logic [15:0] HALT = 16'hF000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pc;

    mips_16_core_top dut (.clk(clk), .rst(rst), .pc(pc));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [15:0] prog  [0:255];
    logic [15:0] m_reg [0:7];
    logic [15:0] m_mem [0:255];
    logic [7:0]  m_halt_pc;
    bit          m_done;

    typedef struct {
        logic [3:0]  op;
        logic [8:0]  a;
        logic [8:0]  b;
        logic [5:0]  f6;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [0:14];

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] enc_i6(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs1, input logic [5:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [15:0] enc_i9(input logic [3:0] op, input logic [2:0] rd,
                                           input logic [8:0] imm);
        return {op, rd, imm};
    endfunction

    function automatic logic [15:0] enc_jmp(input logic [7:0] t);
        return {8'hE0, t};
    endfunction

    function automatic vec_t mk(input logic [3:0] op, input logic [8:0] a, input logic [8:0] b,
                                input logic [5:0] f6, input logic [15:0] exp);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.f6 = f6; v.exp = exp;
        return v;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    task automatic load_and_reset();
        for (int i = 0; i < 256; i++) dut.IF_stage_inst.imem.rom[i] = prog[i];
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Sequential instruction-set interpreter: one instruction per step, no pipeline.
    task automatic model_run();
        logic [7:0]  mpc, nxt;
        logic [15:0] ir, a, b, d, i6, i9, v, ea;
        logic        w;
        for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        mpc = 8'd0;
        m_done = 1'b0;
        m_halt_pc = 8'd0;
        for (int s = 0; s < 4000 && !m_done; s++) begin
            ir  = prog[mpc];
            a   = m_reg[ir[8:6]];
            b   = m_reg[ir[5:3]];
            d   = m_reg[ir[11:9]];
            i6  = {{10{ir[5]}}, ir[5:0]};
            i9  = {{7{ir[8]}}, ir[8:0]};
            ea  = a + i6;
            nxt = mpc + 8'd1;
            w   = 1'b1;
            v   = 16'h0000;
            case (ir[15:12])
                4'd1:  v = a + b;
                4'd2:  v = a - b;
                4'd3:  v = a & b;
                4'd4:  v = a | b;
                4'd5:  v = a ^ b;
                4'd6:  v = a << b[3:0];
                4'd7:  v = a >> b[3:0];
                4'd8:  v = ea;
                4'd9:  v = m_mem[ea[7:0]];
                4'd10: begin w = 1'b0; m_mem[ea[7:0]] = d; end
                4'd11: v = i9;
                4'd12: begin w = 1'b0; if (d == 16'h0000) nxt = mpc + 8'd1 + i9[7:0]; end
                4'd13: begin w = 1'b0; if (d != 16'h0000) nxt = mpc + 8'd1 + i9[7:0]; end
                4'd14: begin w = 1'b0; nxt = ir[7:0]; end
                4'd15: begin w = 1'b0; m_done = 1'b1; m_halt_pc = mpc + 8'd1; end
                default: w = 1'b0;
            endcase
            if (w && ir[11:9] != 3'd0) m_reg[ir[11:9]] = v;
            mpc = nxt;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_pc [0:5];
        exp_pc = '{1, 2, 3, 3, 3, 4};

        vecs[0]  = mk(OP_ADD,  9'd5,   9'd3,   6'o20, 16'h0008);
        vecs[1]  = mk(OP_ADD,  9'd255, 9'd255, 6'o20, 16'h01FE);
        vecs[2]  = mk(OP_SUB,  9'd3,   9'd5,   6'o20, 16'hFFFE);
        vecs[3]  = mk(OP_SUB,  9'h100, 9'd255, 6'o20, 16'hFE01);
        vecs[4]  = mk(OP_AND,  9'd12,  9'd10,  6'o20, 16'h0008);
        vecs[5]  = mk(OP_OR,   9'd12,  9'd10,  6'o20, 16'h000E);
        vecs[6]  = mk(OP_XOR,  9'd12,  9'd10,  6'o20, 16'h0006);
        vecs[7]  = mk(OP_SLL,  9'd3,   9'd4,   6'o20, 16'h0030);
        vecs[8]  = mk(OP_SLL,  9'd1,   9'd15,  6'o20, 16'h8000);
        vecs[9]  = mk(OP_SLL,  9'd1,   9'd16,  6'o20, 16'h0001);
        vecs[10] = mk(OP_SRL,  9'h1F0, 9'd4,   6'o20, 16'h0FFF);
        vecs[11] = mk(OP_SRL,  9'h1FF, 9'd17,  6'o20, 16'h7FFF);
        vecs[12] = mk(OP_ADDI, 9'd0,   9'd0,   6'h3F, 16'hFFFF);
        vecs[13] = mk(OP_ADDI, 9'd5,   9'd0,   6'h1F, 16'h0024);
        vecs[14] = mk(OP_ADDI, 9'd5,   9'd0,   6'h20, 16'hFFE5);

        // Reset, then the dependent ALU chain with its two-cycle interlock.
        clear_prog();
        prog[0] = enc_i9(OP_LI, 3'd1, 9'd5);
        prog[1] = enc_i9(OP_LI, 3'd2, 9'd3);
        prog[2] = enc_r(OP_ADD, 3'd3, 3'd1, 3'd2);
        load_and_reset();
        check("reset_pc", {8'h00, pc}, 16'h0000);
        for (int i = 0; i < 8; i++)
            check($sformatf("reset_r%0d", i), dut.check_inst.re_array[i], 16'h0000);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("chain_pc_edge%0d", i + 1), {8'h00, pc}, 16'(exp_pc[i]));
        end
        check("chain_r1_before_reset", dut.check_inst.re_array[1], 16'd5);
        check("chain_r2_before_reset", dut.check_inst.re_array[2], 16'd3);

        // ADD is now in EX; reset must discard it and clear the architectural state.
        rst = 1'b1;
        tick();
        check("midreset_pc", {8'h00, pc}, 16'h0000);
        for (int i = 0; i < 8; i++)
            check($sformatf("midreset_r%0d", i), dut.check_inst.re_array[i], 16'h0000);
        rst = 1'b0;
        repeat (30) tick();
        check("rerun_r1", dut.check_inst.re_array[1], 16'd5);
        check("rerun_r2", dut.check_inst.re_array[2], 16'd3);
        check("rerun_r3", dut.check_inst.re_array[3], 16'd8);

        // Negative result, shift and discarded r0 write.
        clear_prog();
        prog[0] = enc_i9(OP_LI, 3'd1, 9'd3);
        prog[1] = enc_i9(OP_LI, 3'd2, 9'd5);
        prog[2] = enc_r(OP_SUB, 3'd3, 3'd1, 3'd2);
        prog[3] = enc_i9(OP_LI, 3'd4, 9'd4);
        prog[4] = enc_r(OP_SLL, 3'd5, 3'd1, 3'd4);
        prog[5] = enc_r(OP_ADD, 3'd0, 3'd1, 3'd1);
        prog[6] = HALT;
        load_and_reset();
        repeat (40) tick();
        check("neg_r3", dut.check_inst.re_array[3], 16'hFFFE);
        check("shift_r5", dut.check_inst.re_array[5], 16'h0030);
        check("r0_stays_zero", dut.check_inst.re_array[0], 16'h0000);
        check("neg_halt_pc", {8'h00, pc}, 16'd7);

        // Memory round trip through base+offset addressing.
        clear_prog();
        prog[0] = enc_i9(OP_LI, 3'd1, 9'd100);
        prog[1] = enc_i9(OP_LI, 3'd2, 9'd10);
        prog[2] = enc_i6(OP_SW, 3'd1, 3'd2, 6'd2);
        prog[3] = enc_i6(OP_LW, 3'd4, 3'd2, 6'd2);
        prog[4] = HALT;
        load_and_reset();
        repeat (40) tick();
        check("mem_dmem12", dut.dmem[12], 16'd100);
        check("mem_r4", dut.check_inst.re_array[4], 16'd100);

        // Taken branch, jump, halt.
        clear_prog();
        prog[0] = enc_i9(OP_LI, 3'd1, 9'd0);
        prog[1] = enc_i9(OP_BZ, 3'd1, 9'd2);
        prog[2] = enc_i9(OP_LI, 3'd5, 9'd7);
        prog[3] = enc_i9(OP_LI, 3'd6, 9'd7);
        prog[4] = enc_i9(OP_LI, 3'd7, 9'd9);
        prog[5] = enc_jmp(8'd7);
        prog[6] = enc_i9(OP_LI, 3'd5, 9'd1);
        prog[7] = HALT;
        load_and_reset();
        repeat (40) tick();
        check("br_r5", dut.check_inst.re_array[5], 16'd0);
        check("br_r6", dut.check_inst.re_array[6], 16'd0);
        check("br_r7", dut.check_inst.re_array[7], 16'd9);
        check("br_halt_pc", {8'h00, pc}, 16'd8);
        repeat (10) tick();
        check("br_halt_pc_frozen", {8'h00, pc}, 16'd8);

        // Opcode vector table: LI r1,a; LI r2,b; OP r3,r1,(r2|imm6); HALT.
        for (int i = 0; i < 15; i++) begin
            clear_prog();
            prog[0] = enc_i9(OP_LI, 3'd1, vecs[i].a);
            prog[1] = enc_i9(OP_LI, 3'd2, vecs[i].b);
            prog[2] = {vecs[i].op, 3'd3, 3'd1, vecs[i].f6};
            prog[3] = HALT;
            load_and_reset();
            repeat (25) tick();
            check($sformatf("vec%0d_op%0d_r3", i, vecs[i].op), dut.check_inst.re_array[3], vecs[i].exp);
            check($sformatf("vec%0d_pc", i), {8'h00, pc}, 16'd4);
        end

        // Random programs: DMEM[0..7] zeroed by a store prologue, forward-only control flow.
        for (int t = 0; t < 20; t++) begin
            clear_prog();
            for (int k = 0; k < 8; k++) prog[k] = enc_i6(OP_SW, 3'd0, 3'd0, 6'(k));
            for (int i = 8; i < 32; i++) begin
                logic [2:0] rd, rs1, rs2;
                rd  = 3'($urandom_range(0, 7));
                rs1 = 3'($urandom_range(0, 7));
                rs2 = 3'($urandom_range(0, 7));
                case ($urandom_range(0, 11))
                    0:       prog[i] = 16'h0000;
                    4:       prog[i] = enc_i6(OP_ADDI, rd, rs1, 6'($urandom));
                    5:       prog[i] = enc_i9(OP_LI, rd, 9'($urandom));
                    6:       prog[i] = enc_i6(OP_LW, rd, 3'd0, {3'b000, 3'($urandom)});
                    7:       prog[i] = enc_i6(OP_SW, rd, 3'd0, {3'b000, 3'($urandom)});
                    8:       prog[i] = enc_i9(($urandom_range(0, 1) == 0) ? OP_BZ : OP_BNZ, rd,
                                              9'($urandom_range(0, 31 - i)));
                    9:       prog[i] = enc_jmp(8'($urandom_range(i + 1, 32)));
                    default: prog[i] = enc_r(4'($urandom_range(1, 7)), rd, rs1, rs2);
                endcase
            end
            prog[32] = HALT;
            model_run();
            load_and_reset();
            repeat (200) tick();
            for (int r = 0; r < 8; r++)
                check($sformatf("rand%0d_r%0d", t, r), dut.check_inst.re_array[r], m_reg[r]);
            check($sformatf("rand%0d_halt_pc", t), {8'h00, pc}, {8'h00, m_halt_pc});
            for (int a = 0; a < 8; a++)
                check($sformatf("rand%0d_dmem%0d", t, a), dut.dmem[a], m_mem[a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
